ball_motion_ctrl: RTL and testbench



---
 rtl/ball_motion_ctrl.sv | 132 +++++++++++++
 tb/tb_ball_motion_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball motion sequencer (optional gravity: BALL_GRAVITY_EN)
module ball_motion_ctrl #(
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int STEP     = 1,
    parameter int SIZE     = 4
`ifdef BALL_GRAVITY_EN
    ,
    parameter int GRAV_MAX = 8
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       pause,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic [9:0] BallX_Motion,
    output logic [9:0] BallY_Motion,
    output logic       frame_done
);

    typedef enum logic [1:0] {S_WAIT, S_INPUT, S_BOUNCE, S_MOVE} state_t;

    localparam logic [9:0]  POS_STEP = 10'(STEP);
    localparam logic [9:0]  NEG_STEP = 10'(-STEP);
    localparam logic [10:0] X_HI     = 11'(X_MAX);
    localparam logic [10:0] X_LO     = 11'(X_MIN + SIZE);
    localparam logic [10:0] Y_HI     = 11'(Y_MAX);
    localparam logic [10:0] Y_LO     = 11'(Y_MIN + SIZE);
`ifdef BALL_GRAVITY_EN
    localparam logic [9:0]  GRAV_CAP = 10'(GRAV_MAX);
`endif

    state_t      state;
    logic        s1, s2, s3;
    logic        frame_edge;
    logic [9:0]  key_mx, key_my;
    logic [9:0]  bnc_mx, bnc_my;
    logic [10:0] x_sum, y_sum;

    assign Ball_size  = 10'(SIZE);
    assign frame_edge = s2 & ~s3;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= frame_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        key_mx = BallX_Motion;
        key_my = BallY_Motion;
        case (keycode)
            8'h1A: begin key_mx = '0;       key_my = NEG_STEP; end
            8'h16: begin key_mx = '0;       key_my = POS_STEP; end
            8'h04: begin key_mx = NEG_STEP; key_my = '0;       end
            8'h07: begin key_mx = POS_STEP; key_my = '0;       end
            default: ;
        endcase
`ifdef BALL_GRAVITY_EN
        // W overrides gravity for its frame; otherwise accelerate downward up to the cap
        if (keycode != 8'h1A)
            key_my = ($signed(key_my) >= $signed(GRAV_CAP)) ? GRAV_CAP : key_my + 10'd1;
`endif
    end

    assign x_sum = {1'b0, BallX} + 11'(SIZE);
    assign y_sum = {1'b0, BallY} + 11'(SIZE);

    always_comb begin
        bnc_mx = BallX_Motion;
        bnc_my = BallY_Motion;
        if (x_sum >= X_HI)
            bnc_mx = NEG_STEP;
        else if ({1'b0, BallX} <= X_LO)
            bnc_mx = POS_STEP;
        if (y_sum >= Y_HI)
            bnc_my = NEG_STEP;
        else if ({1'b0, BallY} <= Y_LO)
            bnc_my = POS_STEP;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_WAIT;
            BallX        <= 10'(X_CENTER);
            BallY        <= 10'(Y_CENTER);
            BallX_Motion <= '0;
            BallY_Motion <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (frame_edge && !pause)
                        state <= S_INPUT;
                end
                S_INPUT: begin
                    BallX_Motion <= key_mx;
                    BallY_Motion <= key_my;
                    state        <= S_BOUNCE;
                end
                S_BOUNCE: begin
                    BallX_Motion <= bnc_mx;
                    BallY_Motion <= bnc_my;
                    state        <= S_MOVE;
                end
                S_MOVE: begin
                    BallX      <= BallX + BallX_Motion;
                    BallY      <= BallY + BallY_Motion;
                    frame_done <= 1'b1;
                    state      <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - scoreboard bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       pause = 1'b0;
    logic [9:0] BallX, BallY, Ball_size, BallX_Motion, BallY_Motion;
    logic       frame_done;

    ball_motion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .pause(pause),
        .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
        .BallX_Motion(BallX_Motion), .BallY_Motion(BallY_Motion), .frame_done(frame_done)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] mx;
        logic [9:0] my;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;
    int   x_m = 320, y_m = 240, mx_m = 0, my_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] k);
        exp_t e;
        case (k)
            8'h1A: begin mx_m = 0;  my_m = -1; end
            8'h16: begin mx_m = 0;  my_m = 1;  end
            8'h04: begin mx_m = -1; my_m = 0;  end
            8'h07: begin mx_m = 1;  my_m = 0;  end
            default: ;
        endcase
`ifdef BALL_GRAVITY_EN
        if (k != 8'h1A) my_m = (my_m >= 8) ? 8 : my_m + 1;
`endif
        if (x_m + 4 >= 639) mx_m = -1;
        else if (x_m <= 4)  mx_m = 1;
        if (y_m + 4 >= 479) my_m = -1;
        else if (y_m <= 4)  my_m = 1;
        x_m = (x_m + mx_m + 1024) % 1024;
        y_m = (y_m + my_m + 1024) % 1024;
        e.x  = 10'(x_m);
        e.y  = 10'(y_m);
        e.mx = 10'(mx_m);
        e.my = 10'(my_m);
        sb.push_back(e);
    endtask

    task automatic run_frame(input logic [7:0] k, input int high_cycles);
        @(negedge Clk);
        keycode   = k;
        frame_clk = 1'b1;
        if (!pause) model_frame(k);
        repeat (high_cycles) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (7) @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (!Reset && frame_done) begin
            done_count++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_x",  {22'd0, BallX},        {22'd0, e.x});
                check("sb_y",  {22'd0, BallY},        {22'd0, e.y});
                check("sb_mx", {22'd0, BallX_Motion}, {22'd0, e.mx});
                check("sb_my", {22'd0, BallY_Motion}, {22'd0, e.my});
            end
        end
        prev_done = frame_done;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, pulse_at;
        logic [9:0] sx;

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("rst_x",    {22'd0, BallX}, 32'd320);
        check("rst_y",    {22'd0, BallY}, 32'd240);
        check("rst_mx",   {22'd0, BallX_Motion}, 32'd0);
        check("rst_my",   {22'd0, BallY_Motion}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("size",     {22'd0, Ball_size}, 32'd4);

        // first frame with D: pulse must appear at the 6th falling edge after the rise
        d0 = done_count;
        pulse_at = -1;
        @(negedge Clk);
        keycode   = 8'h07;
        frame_clk = 1'b1;
        model_frame(8'h07);
        for (int i = 1; i <= 9; i++) begin
            @(negedge Clk);
            if (i == 2) frame_clk = 1'b0;
            if (frame_done && pulse_at < 0) pulse_at = i;
        end
        check("latency", 32'(pulse_at), 32'd6);
        check("d_x", {22'd0, BallX}, 32'd321);
        check("d_mx", {22'd0, BallX_Motion}, 32'd1);
        check("d_done_cnt", 32'(done_count - d0), 32'd1);

        for (int g = 0; g < 400 && x_m != 635; g++) run_frame(8'h07, 2);
        check("reach_635", {22'd0, BallX}, 32'd635);
        run_frame(8'h07, 2);
        check("bounce_mx", {22'd0, BallX_Motion}, 32'h3FF);
        check("bounce_x",  {22'd0, BallX}, 32'd634);
        run_frame(8'h07, 2);
        check("reapply_x", {22'd0, BallX}, 32'd635);
        check("reapply_mx", {22'd0, BallX_Motion}, 32'd1);

        @(negedge Clk);
        pause = 1'b1;
        d0 = done_count;
        sx = BallX;
        repeat (3) run_frame(8'h07, 2);
        check("pause_done", 32'(done_count - d0), 32'd0);
        check("pause_x", {22'd0, BallX}, {22'd0, sx});
        @(negedge Clk);
        pause = 1'b0;
        run_frame(8'h07, 2);
        check("unpause_done", 32'(done_count - d0), 32'd1);
        check("unpause_x", {22'd0, BallX}, 32'd634);

        d0 = done_count;
        run_frame(8'h00, 100);
        check("held_done", 32'(done_count - d0), 32'd1);

        // reset while the FSM sits in S_BOUNCE
        d0 = done_count;
        @(negedge Clk);
        keycode   = 8'h07;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_x",  {22'd0, BallX}, 32'd320);
        check("mid_rst_y",  {22'd0, BallY}, 32'd240);
        check("mid_rst_mx", {22'd0, BallX_Motion}, 32'd0);
        check("mid_rst_my", {22'd0, BallY_Motion}, 32'd0);
        check("mid_rst_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        x_m = 320; y_m = 240; mx_m = 0; my_m = 0;
        repeat (10) @(negedge Clk);
        check("mid_rst_no_done", 32'(done_count - d0), 32'd0);

        // steer onto a diagonal that meets the bottom-left corner exactly
        for (int g = 0; g < 400 && x_m != 475; g++) run_frame(8'h07, 2);
        for (int g = 0; g < 400 && y_m != 4; g++)   run_frame(8'h1A, 2);
        run_frame(8'h04, 2);
        for (int g = 0; g < 600 && x_m != 4; g++)   run_frame(8'h00, 2);
        check("corner_pre_x", {22'd0, BallX}, 32'd4);
        check("corner_pre_y", {22'd0, BallY}, 32'd475);
        run_frame(8'h00, 2);
        check("corner_mx", {22'd0, BallX_Motion}, 32'd1);
        check("corner_my", {22'd0, BallY_Motion}, 32'h3FF);
        check("corner_x",  {22'd0, BallX}, 32'd5);
        check("corner_y",  {22'd0, BallY}, 32'd474);

        repeat (5) @(negedge Clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
